// File: rtl/bus_mem_responder.sv
// bus_mem_responder
//   Word-addressed simulation memory acting as the responder on a
//   req/gnt/rvalid host port. Reads and byte-enabled writes are accepted one
//   per cycle. Each accepted request produces exactly one response, in order,
//   LATENCY cycles after its grant. Out-of-range or misaligned accesses get an
//   error response. Those writes are dropped, and those reads return zero.
//
//   Optional build macro: RESP_STALL_EN
//     When defined, a 16-bit LFSR refuses about 1 in 8 pending requests so the
//     host sees grant stalls. When undefined, every request is granted
//     immediately while out of reset.
//
// Ports
//   clk_i     clock
//   rst_i     asynchronous active-high reset
//   req_i     request valid; held with address/data until granted
//   we_i      1 = write, 0 = read
//   addr_i    byte address
//   wdata_i   write data
//   be_i      byte enables (writes only)
//   gnt_o     request accepted this cycle (combinational)
//   rvalid_o  one-cycle response pulse per granted request
//   rdata_o   read data, zero unless a successful read response
//   err_o     error flag, valid with rvalid_o
module bus_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int unsigned LATENCY     = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  logic [31:0] mem [DEPTH_WORDS];

  logic [32:0]      offset;
  logic             addr_err;
  logic [IDX_W-1:0] word_idx;
  logic             stall;
  logic             xfer;
  logic             wr_en;

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] err_q, err_d;
  logic [31:0]        rdata_q [LATENCY];
  logic [31:0]        rdata_d [LATENCY];

  // The subtraction is done in 33 bits so an address below BASE_ADDR borrows
  // into bit 32. That makes the offset exceed SPAN and flags an error rather
  // than aliasing onto a word near the top of the array.
  assign offset   = {1'b0, addr_i} - {1'b0, BASE_ADDR};
  assign addr_err = (offset >= SPAN) | (offset[1:0] != 2'b00);
  assign word_idx = offset[IDX_W+1:2];

`ifdef RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR with taps 16,14,13,11. It shifts left, and the feedback
  // enters at bit 0.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[2:0] == 3'b000);
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign stall       = 1'b0;
`endif

  // Grant is also masked by reset so nothing is accepted while the response
  // pipeline is being cleared.
  assign gnt_o = req_i & ~stall & ~rst_i;
  assign xfer  = gnt_o;

  // Response pipeline next state. Stage 0 captures the granted request. Later
  // stages simply shift. Array data is sampled at the grant edge, so a read
  // granted right after a write sees the written value.
  always_comb begin
    valid_d = '0;
    err_d   = '0;
    wr_en   = xfer & we_i & ~addr_err;
    for (int i = 0; i < LATENCY; i++) begin
      rdata_d[i] = '0;
    end
    for (int i = LATENCY - 1; i > 0; i--) begin
      valid_d[i] = valid_q[i-1];
      err_d[i]   = err_q[i-1];
      rdata_d[i] = rdata_q[i-1];
    end
    valid_d[0] = xfer;
    err_d[0]   = xfer & addr_err;
    if (xfer && !we_i && !addr_err) begin
      rdata_d[0] = mem[word_idx];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int i = 0; i < LATENCY; i++) begin
        rdata_q[i] <= rdata_d[i];
      end
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rvalid_o = valid_q[LATENCY-1];
  assign err_o    = err_q[LATENCY-1];
  assign rdata_o  = rdata_q[LATENCY-1];

endmodule

// File: tb/tb_bus_mem_responder.sv
// tb_bus_mem_responder
//   Directed bench for bus_mem_responder. Two instances share one stimulus
//   stream: one with LATENCY=1 and one with LATENCY=3. Monitors log the grant
//   cycles and the response cycles of each instance. The main sequence then
//   pops them in order and compares them against hand-computed values: the
//   latency, the error flag and the read data.
module tb_bus_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic        gnt1, rvalid1, err1;
  logic [31:0] rdata1;
  logic        gnt3, rvalid3, err3;
  logic [31:0] rdata3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          c;
    logic        e;
    logic [31:0] d;
  } resp_t;

  int    g1_q[$];
  int    g3_q[$];
  resp_t r1_q[$];
  resp_t r3_q[$];

  logic [31:0] burst_exp [8];

  bus_mem_responder #(.LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt1), .rvalid_o(rvalid1),
    .rdata_o(rdata1), .err_o(err1)
  );

  bus_mem_responder #(.LATENCY(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt3), .rvalid_o(rvalid3),
    .rdata_o(rdata3), .err_o(err3)
  );

  always #5 clk = ~clk;

  // Count cycles on the active edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Log grants and responses on the falling edge, where all signals are stable.
  // A grant seen with cycle count N takes effect at the edge that makes it
  // N+1, so the difference between the response and grant stamps is the
  // latency.
  always @(negedge clk) begin
    if (req && gnt1) g1_q.push_back(cyc);
    if (req && gnt3) g3_q.push_back(cyc);
    if (rvalid1) r1_q.push_back('{cyc, err1, rdata1});
    if (rvalid3) r3_q.push_back('{cyc, err3, rdata3});
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request and hold it until it is granted. Inputs change 1
  // time unit after the clock edge. Returns 1 time unit after the grant edge.
  task automatic applyStimulus(input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] b);
    logic got;
    got   = 1'b0;
    we    = w;
    addr  = a;
    wdata = d;
    be    = b;
    req   = 1'b1;
    for (int t = 0; t < 32 && !got; t++) begin
      @(negedge clk);
      if (gnt1) got = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout: observed no grant, expected grant for addr %h", a);
      req = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string tag, input int lat, input int gc, input resp_t r,
                          input logic exp_e, input logic [31:0] exp_d);
    checkVal({tag, "_lat"}, 32'(r.c - gc), 32'(lat));
    checkVal({tag, "_err"}, {31'b0, r.e}, {31'b0, exp_e});
    checkVal({tag, "_rdata"}, r.d, exp_d);
  endtask

  // Pop the oldest grant/response pair of each instance and compare it.
  task automatic checkOutput(input string tag, input logic exp_e, input logic [31:0] exp_d);
    int    gc;
    resp_t r;
    checks++;
    assert (g1_q.size() > 0 && r1_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_l1_present: observed %0d grants %0d responses, expected at least 1 each",
             tag, g1_q.size(), r1_q.size());
    end
    if (g1_q.size() > 0 && r1_q.size() > 0) begin
      gc = g1_q.pop_front();
      r  = r1_q.pop_front();
      checkOne({tag, "_l1"}, 1, gc, r, exp_e, exp_d);
    end
    checks++;
    assert (g3_q.size() > 0 && r3_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_l3_present: observed %0d grants %0d responses, expected at least 1 each",
             tag, g3_q.size(), r3_q.size());
    end
    if (g3_q.size() > 0 && r3_q.size() > 0) begin
      gc = g3_q.pop_front();
      r  = r3_q.pop_front();
      checkOne({tag, "_l3"}, 3, gc, r, exp_e, exp_d);
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    be    = 4'h0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state: outputs are idle, and a pending request is not granted.
    req  = 1'b1;
    addr = 32'h0010_0000;
    @(negedge clk);
    checkVal("reset_gnt1", {31'b0, gnt1}, 32'd0);
    checkVal("reset_gnt3", {31'b0, gnt3}, 32'd0);
    checkVal("reset_rvalid1", {31'b0, rvalid1}, 32'd0);
    checkVal("reset_rvalid3", {31'b0, rvalid3}, 32'd0);
    checkVal("reset_err3", {31'b0, err3}, 32'd0);
    checkVal("reset_rdata3", rdata3, 32'd0);
    @(posedge clk);
    #1;
    req = 1'b0;
    rst = 1'b0;
    idle(1);

    $display("[TB] full write then read");
    applyStimulus(1'b1, 32'h0010_0000, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(1'b0, 32'h0010_0000, 32'h0, 4'h0);
    idle(6);
    checkOutput("wr_full", 1'b0, 32'h0);
    checkOutput("rd_full", 1'b0, 32'hDEAD_BEEF);

    $display("[TB] partial byte-enable write");
    applyStimulus(1'b1, 32'h0010_0004, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(1'b1, 32'h0010_0004, 32'h1122_3344, 4'b0101);
    applyStimulus(1'b0, 32'h0010_0004, 32'h0, 4'h0);
    idle(6);
    checkOutput("wr_ones", 1'b0, 32'h0);
    checkOutput("wr_partial", 1'b0, 32'h0);
    checkOutput("rd_partial", 1'b0, 32'hFF22_FF44);

    $display("[TB] range and alignment errors");
    applyStimulus(1'b0, 32'h0010_1000, 32'h0, 4'h0);
    applyStimulus(1'b1, 32'h0010_0FFC, 32'h1234_5678, 4'hF);
    applyStimulus(1'b0, 32'h0010_0FFC, 32'h0, 4'h0);
    applyStimulus(1'b1, 32'h000F_FFFC, 32'hAAAA_5555, 4'hF);
    applyStimulus(1'b0, 32'h0010_0FFC, 32'h0, 4'h0);
    applyStimulus(1'b1, 32'h0010_0002, 32'h0BAD_F00D, 4'hF);
    applyStimulus(1'b0, 32'h0010_0000, 32'h0, 4'h0);
    applyStimulus(1'b1, 32'h0010_0000, 32'h5555_5555, 4'h0);
    applyStimulus(1'b0, 32'h0010_0000, 32'h0, 4'h0);
    idle(6);
    checkOutput("rd_above_top", 1'b1, 32'h0);
    checkOutput("wr_top_word", 1'b0, 32'h0);
    checkOutput("rd_top_word", 1'b0, 32'h1234_5678);
    checkOutput("wr_below_base", 1'b1, 32'h0);
    checkOutput("rd_no_alias", 1'b0, 32'h1234_5678);
    checkOutput("wr_misaligned", 1'b1, 32'h0);
    checkOutput("rd_after_misal", 1'b0, 32'hDEAD_BEEF);
    checkOutput("wr_be_zero", 1'b0, 32'h0);
    checkOutput("rd_after_be0", 1'b0, 32'hDEAD_BEEF);

    $display("[TB] back-to-back burst");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h0010_0008 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
    end
    idle(6);
    for (int i = 0; i < 6; i++) checkOutput("wr_burst_fill", 1'b0, 32'h0);
    burst_exp[0] = 32'hDEAD_BEEF;
    burst_exp[1] = 32'hFF22_FF44;
    for (int i = 2; i < 8; i++) burst_exp[i] = 32'hA000_0000 + 32'(i - 2);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 32'h0010_0000 + 32'(4 * i), 32'h0, 4'h0);
    end
    idle(6);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("rd_burst%0d", i), 1'b0, burst_exp[i]);

    $display("[TB] reset with responses in flight");
    applyStimulus(1'b1, 32'h0010_0020, 32'hCAFE_F00D, 4'hF);
    idle(6);
    checkOutput("wr_pre_reset", 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0010_0000, 32'h0, 4'h0);
    applyStimulus(1'b0, 32'h0010_0004, 32'h0, 4'h0);
    rst = 1'b1;
    req = 1'b0;
    g1_q.delete();
    g3_q.delete();
    r1_q.delete();
    r3_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(8);
    checkVal("post_reset_resp_l1", 32'(r1_q.size()), 32'd0);
    checkVal("post_reset_resp_l3", 32'(r3_q.size()), 32'd0);
    applyStimulus(1'b0, 32'h0010_0020, 32'h0, 4'h0);
    applyStimulus(1'b0, 32'h0010_0004, 32'h0, 4'h0);
    idle(6);
    checkOutput("rd_retained_a", 1'b0, 32'hCAFE_F00D);
    checkOutput("rd_retained_b", 1'b0, 32'hFF22_FF44);

    checkVal("leftover_resp_l1", 32'(r1_q.size()), 32'd0);
    checkVal("leftover_resp_l3", 32'(r3_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Word-addressed simulation memory that answers the req/gnt/rvalid host protocol, i.e. the responder side of a bus host port.
- Sits behind the compliance-test helper's signature-read host port and the core data port in the compliance testbench.
- Serves reads and byte-enabled writes with a fixed, parameterised response latency, in order.
- Flags out-of-range and misaligned accesses with an error response.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, ≥ 4.
- BASE_ADDR, 32'h0010_0000: byte address of word 0; 4-byte aligned; BASE_ADDR + 4*DEPTH_WORDS ≤ 2^32.
- LATENCY, 1: cycles from grant edge to rvalid_o; legal values 1 to 4.
- LFSR_SEED, 16'hACE1: non-zero seed for the optional stall generator.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_i  in  1  request valid; held with address and data until granted
- we_i  in  1  1 = write, 0 = read
- addr_i  in  32  byte address
- wdata_i  in  32  write data
- be_i  in  4  byte enables for writes; ignored for reads
- gnt_o  out  1  request accepted this cycle (combinational)
- rvalid_o  out  1  response valid, one pulse per granted request
- rdata_o  out  32  read data, valid with rvalid_o
- err_o  out  1  error flag, valid with rvalid_o

Behaviour:
- Reset: rvalid_o=0, err_o=0, rdata_o=0; response pipeline cleared; LFSR loaded with LFSR_SEED; memory contents not reset.
- gnt_o = req_i & ~stall & ~rst_i. stall is 0 unless RESP_STALL_EN is defined.
- Handshake: a transfer occurs in each cycle with req_i & gnt_o. Back-to-back grants are allowed, one per cycle. No response back-pressure exists.
- Address decode:
  - Offset = addr_i - BASE_ADDR, computed in 33 bits.
  - In range iff addr_i ≥ BASE_ADDR and offset < 4*DEPTH_WORDS.
  - Word index = offset[log2(4*DEPTH_WORDS)-1:2].
  - err = ~in_range | (addr_i[1:0] != 0).
- Granted write with err=0: each byte lane with be_i[k]=1 is updated at the grant clock edge. be_i=0 is legal; nothing is written and no error is raised.
- Granted write with err=1: no memory update.
- Granted read: array read at the grant edge; rdata = 0 when err=1.
- Write-then-read ordering:
  - A read granted in cycle N+1 returns data written by a write granted in cycle N.
  - Within a single cycle only one request exists, so no same-cycle hazard arises.
- Response pipeline: a LATENCY-deep shift register of {valid, err, rdata}.
  - Stage 0 is loaded at the grant edge; valid = 1 for both reads and writes.
  - The last stage drives rvalid_o, err_o and rdata_o.
  - Consequence: rvalid_o asserts exactly LATENCY cycles after the grant cycle. With LATENCY=1 it asserts in the cycle after the grant.
  - Responses are strictly in grant order, one per grant.
- rdata_o is 0 whenever rvalid_o=0, and for write responses.
- Reset mid-operation: in-flight responses are discarded (no rvalid_o after reset deassertion); memory contents are retained.
- Top of range: the last word (BASE_ADDR + 4*DEPTH_WORDS - 4) is legal; the next word address is an error.
- Address arithmetic must not wrap below BASE_ADDR: an address below BASE_ADDR is an error, never an aliased word.

Optional Feature:
- Macro: RESP_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle out of reset.
  - stall = (lfsr[2:0] == 3'b000), so roughly 1/8 of cycles refuse a pending request; req_i must stay held.
  - Latency is counted from the actual grant cycle.
- Undefined: no LFSR; gnt_o = req_i whenever out of reset.

Test Plan:
- Write 32'hDEAD_BEEF, be=4'hF, to 32'h0010_0000; then read the same address → read rvalid_o 1 cycle after its grant, rdata_o=32'hDEAD_BEEF, err_o=0.
- Partial write: be=4'b0101, wdata=32'h1122_3344 over 32'hFFFF_FFFF at 32'h0010_0004 → read returns 32'hFF22_FF44.
- Out of range, with DEPTH_WORDS=1024:
  - Read at 32'h0010_1000 → err_o=1, rdata_o=0.
  - Read at 32'h0010_0FFC → err_o=0.
  - Write at 32'h000F_FFFC → err_o=1, memory unchanged.
- Misaligned write at 32'h0010_0002 → err_o=1, target word unchanged.
- Back-to-back with LATENCY=3: 8 consecutive granted reads → 8 consecutive rvalid_o pulses starting 3 cycles after the first grant, data in order.
- Reset asserted 1 cycle after 2 grants with LATENCY=3 → no rvalid_o after release; previously written data still readable. With RESP_STALL_EN defined, held requests each get exactly one response.
